// File: rtl/avm_arb_pkg.sv
// avm_arb_pkg: shared state/grant enums and default widths for avm_burst_arbiter.
package avm_arb_pkg;
  localparam int AVM_ADDR_W  = 26;
  localparam int AVM_DATA_W  = 16;
  localparam int AVM_BURST_W = 8;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_e;
  typedef enum logic {GNT_WR, GNT_RD} grant_e;
endpackage

// File: rtl/avm_arb_beat_cnt.sv
// avm_arb_beat_cnt: write-burst beat counter; a zero burstcount loads as a single beat.
module avm_arb_beat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? (load_val == '0 ? W'(1) : load_val) : dec ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last = cnt_q == W'(1);
endmodule

// File: rtl/avm_burst_arbiter.sv
// avm_burst_arbiter: arbitrates a write master and a read master onto one Avalon-MM burst slave.
// Define AVM_ARB_RR_EN for round-robin conflict resolution; otherwise write beats read.
module avm_burst_arbiter
  import avm_arb_pkg::*;
#(
  parameter int ADDR_W  = AVM_ADDR_W,
  parameter int DATA_W  = AVM_DATA_W,
  parameter int BURST_W = AVM_BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  wr_address,
  input  logic               wr_write,
  input  logic [DATA_W-1:0]  wr_writedata,
  input  logic [BURST_W-1:0] wr_burstcount,
  output logic               wr_waitrequest,
  input  logic [ADDR_W-1:0]  rd_address,
  input  logic               rd_read,
  input  logic [BURST_W-1:0] rd_burstcount,
  output logic               rd_waitrequest,
  output logic [DATA_W-1:0]  rd_readdata,
  output logic               rd_readdatavalid,
  output logic [ADDR_W-1:0]  s_address,
  output logic               s_write,
  output logic               s_read,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [BURST_W-1:0] s_burstcount,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid
);
  state_e state_q, state_d;
  logic   idle, in_wr, in_rd, wr_win, wr_acc, rd_acc, last_beat;
`ifdef AVM_ARB_RR_EN
  grant_e last_grant_q, last_grant_d;
  // a contested grant goes to the master that was not served last
  assign wr_win = wr_write && !(rd_read && last_grant_q == GNT_WR);
  always_comb last_grant_d = idle && wr_win ? GNT_WR : idle && rd_read ? GNT_RD : last_grant_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant_q <= GNT_RD;
    else last_grant_q <= last_grant_d;
`else
  assign wr_win = wr_write;
`endif
  always_comb begin
    idle   = state_q == IDLE;
    in_wr  = state_q == WR_BURST;
    in_rd  = state_q == RD_CMD;
    wr_acc = in_wr && wr_write && !s_waitrequest;
    rd_acc = in_rd && rd_read && !s_waitrequest;
    state_d = idle ? (wr_win ? WR_BURST : rd_read ? RD_CMD : IDLE)
            : ((wr_acc && last_beat) || rd_acc) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  avm_arb_beat_cnt #(.W(BURST_W)) u_beat_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (idle && wr_win),
    .dec      (wr_acc),
    .load_val (wr_burstcount),
    .last     (last_beat)
  );
  // async reset forces IDLE, which alone drives the quiet slave-side values
  always_comb begin
    s_address        = in_wr ? wr_address : in_rd ? rd_address : '0;
    s_write          = in_wr && wr_write;
    s_read           = in_rd && rd_read;
    s_writedata      = in_wr ? wr_writedata : '0;
    s_burstcount     = in_wr ? wr_burstcount : in_rd ? rd_burstcount : '0;
    wr_waitrequest   = in_wr ? s_waitrequest : 1'b1;
    rd_waitrequest   = in_rd ? s_waitrequest : 1'b1;
    rd_readdata      = s_readdata;
    rd_readdatavalid = s_readdatavalid;
  end
endmodule

// File: tb/tb_avm_burst_arbiter.sv
// tb_avm_burst_arbiter: directed bench with a transaction-level reference model and per-cycle compare.
module tb_avm_burst_arbiter;
`ifdef AVM_ARB_RR_EN
  localparam bit RR = 1'b1;
  localparam int EXP_ORDER = 121;
`else
  localparam bit RR = 1'b0;
  localparam int EXP_ORDER = 111;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [25:0] wr_address = 26'h0, rd_address = 26'h0, s_address;
  logic        wr_write = 1'b0, rd_read = 1'b0, wr_waitrequest, rd_waitrequest;
  logic [15:0] wr_writedata = 16'h0, rd_readdata, s_writedata, s_readdata = 16'h0;
  logic [7:0]  wr_burstcount = 8'h0, rd_burstcount = 8'h0, s_burstcount;
  logic        rd_readdatavalid, s_write, s_read, s_waitrequest = 1'b0, s_readdatavalid = 1'b0;
  int vectors = 0, miscompares = 0;
  int owner = 0, left = 0, last = 2;
  int dut_wr_beats = 0, dut_rd_cmds = 0, dut_rvalid_in_wr = 0;
  int dut_grants[$], model_grants[$];
  logic [70:0] exp_v, act_v;
  logic wrg, rdg;
  always #5 clk = ~clk;
  avm_burst_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_burstcount(wr_burstcount), .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .s_address(s_address), .s_write(s_write), .s_read(s_read), .s_writedata(s_writedata),
    .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid)
  );
  // owner: 0 nobody, 1 write master, 2 read master; left = write beats still owed
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner = 0; left = 0; last = 2;
    end else if (owner == 0) begin
      if (wr_write && !(RR && rd_read && last == 1)) begin
        owner = 1; left = (wr_burstcount == 0) ? 1 : int'(wr_burstcount); last = 1; model_grants.push_back(1);
      end else if (rd_read) begin
        owner = 2; last = 2; model_grants.push_back(2);
      end
    end else if (owner == 1 && wr_write && !s_waitrequest) begin
      left = left - 1;
      if (left == 0) owner = 0;
    end else if (owner == 2 && rd_read && !s_waitrequest) owner = 0;
  end
  always @(negedge clk) begin
    wrg = owner == 1;
    rdg = owner == 2;
    exp_v = {wrg ? wr_address : rdg ? rd_address : 26'h0, wrg & wr_write, rdg & rd_read,
             wrg ? wr_writedata : 16'h0, wrg ? wr_burstcount : rdg ? rd_burstcount : 8'h0,
             wrg ? s_waitrequest : 1'b1, rdg ? s_waitrequest : 1'b1, s_readdata, s_readdatavalid};
    act_v = {s_address, s_write, s_read, s_writedata, s_burstcount,
             wr_waitrequest, rd_waitrequest, rd_readdata, rd_readdatavalid};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
    if (s_write && !s_waitrequest) begin dut_wr_beats++; dut_grants.push_back(1); end
    if (s_read && !s_waitrequest) begin dut_rd_cmds++; dut_grants.push_back(2); end
    if (s_write && rd_readdatavalid) dut_rvalid_in_wr++;
  end
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_pin(input string name);
    check(name, {s_write, s_read, wr_waitrequest, rd_waitrequest}, 4'b0011);
  endtask
  int base, ord;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    wr_write = 1'b1; wr_address = 26'h123; wr_writedata = 16'hBEEF; wr_burstcount = 8'd4;
    cyc();
    idle_pin("reset_idle");
    check("reset_addr_zero", int'(s_address), 0);
    check("reset_wdata_zero", int'(s_writedata), 0);
    wr_write = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    // single 4-beat write
    base = dut_wr_beats;
    wr_write = 1'b1; wr_address = 26'h40; wr_burstcount = 8'd4;
    cyc();
    for (int i = 0; i < 4; i++) begin wr_writedata = 16'hA000 + 16'(i); cyc(); end
    wr_write = 1'b0;
    @(negedge clk); #1;
    check("wr4_beats", dut_wr_beats - base, 4);
    idle_pin("wr4_idle_after");
    cyc();
    // 3-beat write with two stall cycles on beat 2
    base = dut_wr_beats;
    wr_write = 1'b1; wr_address = 26'h80; wr_burstcount = 8'd3; wr_writedata = 16'hB001;
    cyc();
    cyc();
    wr_writedata = 16'hB002; s_waitrequest = 1'b1;
    cyc();
    check("bp_wr_wait_mirror", int'(wr_waitrequest), 1);
    cyc();
    s_waitrequest = 1'b0;
    cyc();
    wr_writedata = 16'hB003;
    cyc();
    wr_write = 1'b0;
    @(negedge clk); #1;
    check("bp_beats", dut_wr_beats - base, 3);
    idle_pin("bp_idle_after");
    cyc();
    // 8-beat read command, data returned during a following write grant
    base = dut_rd_cmds;
    rd_read = 1'b1; rd_address = 26'h100; rd_burstcount = 8'd8;
    cyc();
    check("rd_s_read", int'(s_read), 1);
    check("rd_s_addr", int'(s_address), 'h100);
    cyc();
    rd_read = 1'b0;
    wr_write = 1'b1; wr_address = 26'h200; wr_burstcount = 8'd8;
    cyc();
    base = dut_rd_cmds - base;
    check("rd_cmd_once", base, 1);
    base = dut_rvalid_in_wr;
    for (int i = 0; i < 8; i++) begin
      wr_writedata = 16'hC000 + 16'(i); s_readdata = 16'h5500 + 16'(i); s_readdatavalid = 1'b1;
      cyc();
    end
    s_readdatavalid = 1'b0; wr_write = 1'b0;
    check("rvalid_during_wr", dut_rvalid_in_wr - base, 8);
    cyc();
    // zero burstcount is one beat
    base = dut_wr_beats;
    wr_write = 1'b1; wr_address = 26'h300; wr_burstcount = 8'd0; wr_writedata = 16'hD00D;
    cyc();
    cyc();
    @(negedge clk); #1;
    check("bc0_beats", dut_wr_beats - base, 1);
    idle_pin("bc0_bubble");
    wr_write = 1'b0;
    cyc();
    // reset at beat 2 of 4
    wr_write = 1'b1; wr_address = 26'h3F0; wr_burstcount = 8'd4; wr_writedata = 16'hE001;
    cyc();
    cyc();
    wr_writedata = 16'hE002;
    #1 reset_n = 1'b0;
    #1;
    idle_pin("rst_mid_burst");
    check("rst_addr_zero", int'(s_address), 0);
    wr_write = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    idle_pin("rst_idle_after");
    // three back-to-back conflicts
    dut_grants.delete();
    model_grants.delete();
    wr_write = 1'b1; wr_burstcount = 8'd1; wr_address = 26'h10; wr_writedata = 16'hF00F;
    rd_read = 1'b1; rd_burstcount = 8'd2; rd_address = 26'h20;
    repeat (6) cyc();
    wr_write = 1'b0; rd_read = 1'b0;
    cyc();
    check("conflict_count", dut_grants.size(), 3);
    ord = 0;
    foreach (dut_grants[i]) ord = ord * 10 + dut_grants[i];
    check("conflict_order", ord, EXP_ORDER);
    ord = 0;
    foreach (model_grants[i]) ord = ord * 10 + model_grants[i];
    check("model_conflict_order", ord, EXP_ORDER);
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
